// File: rtl/grf_pkg.sv
// rtl/grf_pkg.sv - shared defaults and constants for the general register file
//
// Purpose : default geometry of the register file, the hardwired-zero register
//           address and the reset value used by every stored register.
// Ports   : none (package).

package grf_pkg;

   localparam int GRF_WIDTH = 32;
   localparam int GRF_NREG  = 32;
   localparam int GRF_AW    = 5;

   // Address of the register that always reads as zero and is never written.
   localparam int ZERO_REG = 0;

   localparam logic [GRF_WIDTH-1:0] RESET_VAL = '0;

endpackage

// File: rtl/grf_read_port.sv
// rtl/grf_read_port.sv - one combinational read port of the register file
//
// Purpose : returns zero for register 0, the in-flight write data when the
//           bypass is enabled and the write hits this address, otherwise the
//           stored value.
// Ports   : ra_i     read address
//           byp_en_i a commit is being presented this cycle (reset released, we, wa!=0)
//           wa_i     write address
//           wd_i     write data
//           rf_i     register file contents, entry 0 is the constant zero
//           rd_o     read data

module grf_read_port
   import grf_pkg::*;
#(
   parameter int WIDTH  = GRF_WIDTH,
   parameter int NREG   = GRF_NREG,
   parameter int AW     = GRF_AW,
   parameter int BYPASS = 1
) (
   input  logic [AW-1:0]    ra_i,
   input  logic             byp_en_i,
   input  logic [AW-1:0]    wa_i,
   input  logic [WIDTH-1:0] wd_i,
   input  logic [WIDTH-1:0] rf_i [NREG],
   output logic [WIDTH-1:0] rd_o
);

   always_comb begin
      rd_o = WIDTH'(RESET_VAL);
      if (ra_i == AW'(ZERO_REG)) begin
         rd_o = WIDTH'(RESET_VAL);
      end else if ((BYPASS != 0) && byp_en_i && (wa_i == ra_i)) begin
         rd_o = wd_i;
      end else begin
         rd_o = rf_i[ra_i];
      end
   end

endmodule

// File: rtl/grf_writeback.sv
// rtl/grf_writeback.sv - write-back register file with bypass and commit trace
//
// Purpose : commits the write-back mux result into architectural registers,
//           serves two combinational read ports and publishes a registered
//           commit trace.
// Ports   : clk         rising-edge clock
//           reset       asynchronous active-low reset
//           we, wa, wd  write enable, address, data
//           pc          PC of the writing instruction (trace only)
//           ra1, ra2    read addresses
//           rd1, rd2    read data
//           trace_valid one-cycle pulse per commit
//           trace_pc, trace_addr, trace_data  details of the last commit

module grf_writeback
   import grf_pkg::*;
#(
   parameter int WIDTH  = GRF_WIDTH,
   parameter int NREG   = GRF_NREG,
   parameter int AW     = GRF_AW,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [WIDTH-1:0] pc,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic             trace_valid,
   output logic [WIDTH-1:0] trace_pc,
   output logic [AW-1:0]    trace_addr,
   output logic [WIDTH-1:0] trace_data
);

   logic             commit;
   logic             byp_en;
   logic [WIDTH-1:0] rf_view [NREG];

   assign commit = we && (wa != AW'(ZERO_REG));
   // The bypass is gated by reset so every register reads zero while reset is held.
   assign byp_en = reset && commit;

   // Register 0 is a decoded constant; only 1..NREG-1 are flops.
   assign rf_view[0] = WIDTH'(RESET_VAL);

   for (genvar i = 1; i < NREG; i++) begin : g_reg
      logic             wr_hit;
      logic [WIDTH-1:0] r_q;
      logic [WIDTH-1:0] r_d;

      assign wr_hit = commit && (wa == AW'(i));
      assign r_d    = wr_hit ? wd : r_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_q <= WIDTH'(RESET_VAL);
         end else begin
            r_q <= r_d;
         end
      end

      assign rf_view[i] = r_q;
   end

   grf_read_port #(
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .AW    (AW),
      .BYPASS(BYPASS)
   ) u_rp1 (
      .ra_i    (ra1),
      .byp_en_i(byp_en),
      .wa_i    (wa),
      .wd_i    (wd),
      .rf_i    (rf_view),
      .rd_o    (rd1)
   );

   grf_read_port #(
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .AW    (AW),
      .BYPASS(BYPASS)
   ) u_rp2 (
      .ra_i    (ra2),
      .byp_en_i(byp_en),
      .wa_i    (wa),
      .wd_i    (wd),
      .rf_i    (rf_view),
      .rd_o    (rd2)
   );

   // Commit trace: valid pulses every committing edge, payload holds between commits.
   logic             trace_valid_q, trace_valid_d;
   logic [WIDTH-1:0] trace_pc_q,    trace_pc_d;
   logic [AW-1:0]    trace_addr_q,  trace_addr_d;
   logic [WIDTH-1:0] trace_data_q,  trace_data_d;

   always_comb begin
      trace_valid_d = commit;
      trace_pc_d    = trace_pc_q;
      trace_addr_d  = trace_addr_q;
      trace_data_d  = trace_data_q;
      if (commit) begin
         trace_pc_d   = pc;
         trace_addr_d = wa;
         trace_data_d = wd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trace_valid_q <= 1'b0;
         trace_pc_q    <= '0;
         trace_addr_q  <= '0;
         trace_data_q  <= '0;
      end else begin
         trace_valid_q <= trace_valid_d;
         trace_pc_q    <= trace_pc_d;
         trace_addr_q  <= trace_addr_d;
         trace_data_q  <= trace_data_d;
      end
   end

   assign trace_valid = trace_valid_q;
   assign trace_pc    = trace_pc_q;
   assign trace_addr  = trace_addr_q;
   assign trace_data  = trace_data_q;

endmodule
